seg_scanner: RTL

- Parametrised multiplexed seven-segment display driver for N digits.
- Replaces the fixed two-digit scan in the game top level. Provides per-digit hex decode, frame-synchronous (tear-free) value loading, a per-dwell anti-ghosting blank guard, per-digit blanking and blinking, and a polarity-invert strap.
- Sits between the game logic (score/level values) and the uio segment pins / uo digit-select pins.

---
 rtl/seg_scanner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scanner.sv
// Multiplexed N-digit seven-segment driver: hex decode, tear-free frame loading,
// per-dwell blank guard, per-digit blank/blink, polarity-invert strap.
// Latency: outputs registered, 1 cycle behind scan state. No backpressure; load is accepted every cycle.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   invert         1 = common-anode polarity; digit_sel/segments complemented
//   load           one-cycle capture of digits_in/blank_mask/blink_mask into staging
//   digits_in      hex nibble per digit, digit i = bits [4i+3:4i]
//   blank_mask     1 = digit never lit
//   blink_mask     1 = digit blinks with period 2*BLINK_FRAMES frames
//   digit_sel      one-hot digit enable (polarity per invert)
//   segments       bit0=a .. bit6=g (polarity per invert)
//   frame_start    pulse on the first output cycle of digit 0 (never inverted)
module seg_scanner #(
   parameter int DIGITS       = 2,
   parameter int DWELL        = 1024,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                invert,
   input  logic                load,
   input  logic [4*DIGITS-1:0] digits_in,
   input  logic [DIGITS-1:0]   blank_mask,
   input  logic [DIGITS-1:0]   blink_mask,
   output logic [DIGITS-1:0]   digit_sel,
   output logic [6:0]          segments,
   output logic                frame_start
);

   localparam int DW_W  = (DWELL > 1)        ? $clog2(DWELL)        : 1;
   localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
   localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0]  BLANK_END  = DW_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

   typedef enum logic {
      PHASE_VISIBLE = 1'b0,
      PHASE_HIDDEN  = 1'b1
   } blink_phase_t;

   // scan state
   logic [DW_W-1:0]     dwell_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic [FR_W-1:0]     frame_cnt;
   blink_phase_t        blink_phase;

   // staging (written by load) and active (used for display) value sets
   logic [4*DIGITS-1:0] stg_digits;
   logic [DIGITS-1:0]   stg_blank;
   logic [DIGITS-1:0]   stg_blink;
   logic [4*DIGITS-1:0] act_digits;
   logic [DIGITS-1:0]   act_blank;
   logic [DIGITS-1:0]   act_blink;
   logic                load_pending;

   // combinational view of the current scan slot
   logic                dwell_wrap;
   logic                frame_boundary;
   logic                frame_head;
   logic [3:0]          cur_nib;
   logic                cur_blank;
   logic                cur_blink;
   logic                lit;
   logic [DIGITS-1:0]   sel_l;
   logic [6:0]          seg_l;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      dwell_wrap     = (dwell_cnt == DWELL_LAST);
      frame_boundary = dwell_wrap && (digit_idx == IDX_LAST);
      frame_head     = (dwell_cnt == '0) && (digit_idx == '0);

      // mux the active values of the selected digit
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_nib   = act_digits[4*i +: 4];
            cur_blank = act_blank[i];
            cur_blink = act_blink[i];
         end
      end

      // leading BLANK_CYCLES of every dwell stay dark so the previous digit's
      // segments never ghost onto the newly selected one
      lit = (dwell_cnt >= BLANK_END) && !cur_blank &&
            !(cur_blink && (blink_phase == PHASE_HIDDEN));

      sel_l = '0;
      for (int i = 0; i < DIGITS; i++) begin
         sel_l[i] = lit && (digit_idx == IDX_W'(i));
      end
      seg_l = lit ? hex7(cur_nib) : 7'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_cnt    <= '0;
         digit_idx    <= '0;
         frame_cnt    <= '0;
         blink_phase  <= PHASE_VISIBLE;
         stg_digits   <= '0;
         stg_blank    <= '0;
         stg_blink    <= '0;
         act_digits   <= '0;
         act_blank    <= '0;
         act_blink    <= '0;
         load_pending <= 1'b0;
         frame_start  <= 1'b0;
         digit_sel    <= {DIGITS{invert}};
         segments     <= {7{invert}};
      end else begin
         // scan counters
         if (dwell_wrap) begin
            dwell_cnt <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
         end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
         end

         // blink timebase advances once per frame
         if (frame_boundary) begin
            if (frame_cnt == FRAME_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= (blink_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end

         // Active values only change on the frame boundary. A load landing on
         // the boundary itself bypasses staging so it is not delayed a frame.
         if (frame_boundary) begin
            if (load) begin
               act_digits <= digits_in;
               act_blank  <= blank_mask;
               act_blink  <= blink_mask;
            end else if (load_pending) begin
               act_digits <= stg_digits;
               act_blank  <= stg_blank;
               act_blink  <= stg_blink;
            end
            load_pending <= 1'b0;
         end else if (load) begin
            stg_digits   <= digits_in;
            stg_blank    <= blank_mask;
            stg_blink    <= blink_mask;
            load_pending <= 1'b1;
         end

         // registered outputs; invert applied live, frame_start never inverted
         frame_start <= frame_head;
         digit_sel   <= sel_l ^ {DIGITS{invert}};
         segments    <= seg_l ^ {7{invert}};
      end
   end

endmodule
